// File: rtl/udp_loop_fifo_reader.sv
// Read-side drain for the UDP loopback FIFO: decides packet size from the water level,
// launches the UDP transmitter and maps its byte requests onto FIFO read enables.
module udp_loop_fifo_reader #(
    parameter int unsigned PKT_MAX_LEN = 1024,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned LVL_W       = 12
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             fifo_rempty,
    input  logic [LVL_W-1:0] fifo_rd_water_level,
    output logic             fifo_r_en,
    input  logic [7:0]       fifo_rdata,
    output logic             tx_start_en,
    output logic [15:0]      tx_byte_num,
    input  logic             tx_req,
    output logic [7:0]       tx_data,
    input  logic             tx_done,
    output logic             busy,
    output logic             underrun_err
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [LVL_W-1:0]   lvl_q;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]   sent_cnt;
    logic [CNT_W-1:0]   byte_num;
    logic [CNT_W-1:0]   sent_cnt_inc;
    logic               rd_q;
    logic [7:0]         data_q;

    assign sent_cnt_inc = sent_cnt + 16'd1;
    assign tx_byte_num  = byte_num;

    // Read enable is combinational so FIFO read latency matches the transmitter's next-cycle sample.
    always_comb begin
        fifo_r_en = 1'b0;
        if (!rrst && state == SEND && tx_req && !fifo_rempty && (sent_cnt < byte_num)) begin
            fifo_r_en = 1'b1;
        end
    end

    // Present fresh FIFO data the cycle after a read, otherwise hold the last byte.
    assign tx_data = rd_q ? fifo_rdata : data_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state        <= IDLE;
            lvl_q        <= '0;
            idle_cnt     <= '0;
            sent_cnt     <= '0;
            byte_num     <= '0;
            rd_q         <= 1'b0;
            data_q       <= '0;
            tx_start_en  <= 1'b0;
            busy         <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            lvl_q       <= fifo_rd_water_level;
            tx_start_en <= 1'b0;
            rd_q        <= fifo_r_en;
            if (rd_q) begin
                data_q <= fifo_rdata;
            end

            case (state)
                IDLE: begin
                    if (32'(lvl_q) >= PKT_MAX_LEN) begin
                        byte_num    <= 16'(PKT_MAX_LEN);
                        idle_cnt    <= '0;
                        state       <= START;
                        tx_start_en <= 1'b1;
                        busy        <= 1'b1;
                    end else if (lvl_q != '0) begin
                        if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                            byte_num    <= 16'(lvl_q);
                            idle_cnt    <= '0;
                            state       <= START;
                            tx_start_en <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                START: begin
                    sent_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    // An early tx_done aborts; unread bytes remain for the next packet.
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fifo_r_en) begin
                        sent_cnt <= sent_cnt_inc;
                        if (sent_cnt_inc == byte_num) begin
                            state <= WAIT_DONE;
                        end
                    end
                    if (tx_req && fifo_rempty) begin
                        underrun_err <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_loop_fifo_reader.sv
// Directed bench for udp_loop_fifo_reader with a behavioural FIFO and a byte-order monitor.
module tb_udp_loop_fifo_reader;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic        fifo_rempty;
    logic [11:0] fifo_rd_water_level;
    logic        fifo_r_en;
    logic [7:0]  fifo_rdata = 8'd0;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        underrun_err;

    logic        force_empty = 1'b0;
    logic [7:0]  mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          checks = 0;
    int          errors = 0;

    int          rd_cnt = 0;
    int          start_cnt = 0;
    int          order_err = 0;
    logic        rd_prev = 1'b0;
    logic [7:0]  exp_byte = 8'd0;

    udp_loop_fifo_reader #(
        .PKT_MAX_LEN(1024),
        .TIMEOUT_CYC(8),
        .LVL_W(12)
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .fifo_rempty(fifo_rempty),
        .fifo_rd_water_level(fifo_rd_water_level),
        .fifo_r_en(fifo_r_en),
        .fifo_rdata(fifo_rdata),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_req(tx_req),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .underrun_err(underrun_err)
    );

    always #5 rclk = ~rclk;

    assign fifo_rempty         = (wr_ptr == rd_ptr) || force_empty;
    assign fifo_rd_water_level = 12'(wr_ptr - rd_ptr);

    always @(posedge rclk) begin
        if (fifo_r_en && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= mem[rd_ptr[11:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Bytes are written as their running index, so every read must come back in order.
    always @(negedge rclk) begin
        if (rd_prev) begin
            if (tx_data !== exp_byte) order_err <= order_err + 1;
            exp_byte <= exp_byte + 8'd1;
        end
        rd_prev <= fifo_r_en;
        if (fifo_r_en === 1'b1) rd_cnt <= rd_cnt + 1;
        if (tx_start_en === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[11:0]] = 8'(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        @(negedge rclk);
        while (tx_start_en !== 1'b1 && lat < 40) begin
            @(negedge rclk);
            lat++;
        end
        @(posedge rclk); #1;
    endtask

    task automatic drive_req(input int n);
        for (int i = 0; i < n; i++) begin
            tx_req = 1'b1;
            @(posedge rclk); #1;
        end
        tx_req = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(posedge rclk); #1;
        tx_done = 1'b0;
        @(posedge rclk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge rclk); #1;
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        idle_cycles(3);
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got %b want 0", fifo_r_en); end
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL reset_byte_num got %0d want 0", tx_byte_num); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL reset_tx_data got %0d want 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun_err); end
        rrst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_short_flush();
        int lat, rd0, st0;
        rd0 = rd_cnt; st0 = start_cnt;
        write_bytes(10);
        wait_start(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL flush_latency got %0d want 9", lat); end
        checks++; if (tx_byte_num !== 16'd10) begin errors++; $display("FAIL flush_byte_num got %0d want 10", tx_byte_num); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b want 1", busy); end
        drive_req(12);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 10) begin errors++; $display("FAIL flush_reads got %0d want 10", rd_cnt - rd0); end
        checks++; if (tx_data !== 8'd9) begin errors++; $display("FAIL flush_last_data got %0d want 9", tx_data); end
        pulse_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", busy); end
        checks++; if (start_cnt - st0 != 1) begin errors++; $display("FAIL flush_starts got %0d want 1", start_cnt - st0); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL flush_order got %0d errors want 0", order_err); end
    endtask

    task automatic test_full_burst();
        int lat, rd0, st0;
        rd0 = rd_cnt; st0 = start_cnt;
        write_bytes(1500);
        wait_start(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL burst_latency got %0d want 2", lat); end
        checks++; if (tx_byte_num !== 16'd1024) begin errors++; $display("FAIL burst_byte_num got %0d want 1024", tx_byte_num); end
        drive_req(1030);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 1024) begin errors++; $display("FAIL burst_reads got %0d want 1024", rd_cnt - rd0); end
        checks++; if (tx_byte_num !== 16'd1024) begin errors++; $display("FAIL burst_byte_num_hold got %0d want 1024", tx_byte_num); end
        pulse_done();
        rd0 = rd_cnt;
        wait_start(lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL tail_latency got %0d want 7", lat); end
        checks++; if (tx_byte_num !== 16'd476) begin errors++; $display("FAIL tail_byte_num got %0d want 476", tx_byte_num); end
        drive_req(476);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 476) begin errors++; $display("FAIL tail_reads got %0d want 476", rd_cnt - rd0); end
        pulse_done();
        checks++; if (start_cnt - st0 != 2) begin errors++; $display("FAIL burst_starts got %0d want 2", start_cnt - st0); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL burst_order got %0d errors want 0", order_err); end
    endtask

    task automatic test_boundary();
        int lat, rd0;
        rd0 = rd_cnt;
        write_bytes(1023);
        wait_start(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL b1023_latency got %0d want 9", lat); end
        checks++; if (tx_byte_num !== 16'd1023) begin errors++; $display("FAIL b1023_byte_num got %0d want 1023", tx_byte_num); end
        drive_req(1023);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 1023) begin errors++; $display("FAIL b1023_reads got %0d want 1023", rd_cnt - rd0); end
        pulse_done();
        rd0 = rd_cnt;
        write_bytes(1024);
        wait_start(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL b1024_latency got %0d want 2", lat); end
        checks++; if (tx_byte_num !== 16'd1024) begin errors++; $display("FAIL b1024_byte_num got %0d want 1024", tx_byte_num); end
        drive_req(1024);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 1024) begin errors++; $display("FAIL b1024_reads got %0d want 1024", rd_cnt - rd0); end
        pulse_done();
        checks++; if (order_err != 0) begin errors++; $display("FAIL boundary_order got %0d errors want 0", order_err); end
    endtask

    task automatic test_over_request();
        int lat, rd0, base;
        logic [7:0] last;
        rd0 = rd_cnt; base = wr_ptr;
        last = 8'(base + 63);
        write_bytes(64);
        wait_start(lat);
        checks++; if (tx_byte_num !== 16'd64) begin errors++; $display("FAIL over_byte_num got %0d want 64", tx_byte_num); end
        drive_req(70);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 64) begin errors++; $display("FAIL over_reads got %0d want 64", rd_cnt - rd0); end
        checks++; if (tx_data !== last) begin errors++; $display("FAIL over_hold_data got %0d want %0d", tx_data, last); end
        checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL over_underrun got %b want 0", underrun_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL over_wait_busy got %b want 1", busy); end
        pulse_done();
    endtask

    task automatic test_underrun();
        int lat, rd0;
        rd0 = rd_cnt;
        write_bytes(5);
        wait_start(lat);
        force_empty = 1'b1;
        tx_req = 1'b1;
        @(negedge rclk);
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL under_r_en got %b want 0", fifo_r_en); end
        @(posedge rclk); #1;
        @(posedge rclk); #1;
        tx_req = 1'b0;
        force_empty = 1'b0;
        checks++; if (underrun_err !== 1'b1) begin errors++; $display("FAIL under_flag got %b want 1", underrun_err); end
        checks++; if (rd_cnt - rd0 != 0) begin errors++; $display("FAIL under_no_reads got %0d want 0", rd_cnt - rd0); end
        drive_req(7);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 5) begin errors++; $display("FAIL under_resume_reads got %0d want 5", rd_cnt - rd0); end
        pulse_done();
        checks++; if (underrun_err !== 1'b1) begin errors++; $display("FAIL under_sticky got %b want 1", underrun_err); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL under_order got %0d errors want 0", order_err); end
    endtask

    task automatic test_reset_mid_send();
        int lat, rd0;
        rd0 = rd_cnt;
        write_bytes(300);
        wait_start(lat);
        checks++; if (tx_byte_num !== 16'd300) begin errors++; $display("FAIL rms_byte_num got %0d want 300", tx_byte_num); end
        drive_req(120);
        checks++; if (rd_cnt - rd0 != 120) begin errors++; $display("FAIL rms_partial_reads got %0d want 120", rd_cnt - rd0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rms_busy_before got %b want 1", busy); end
        rrst = 1'b1;
        @(posedge rclk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy got %b want 0", busy); end
        checks++; if (tx_byte_num !== 16'd0) begin errors++; $display("FAIL rms_byte_num_clr got %0d want 0", tx_byte_num); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL rms_tx_data got %0d want 0", tx_data); end
        checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL rms_underrun got %b want 0", underrun_err); end
        checks++; if (tx_start_en !== 1'b0) begin errors++; $display("FAIL rms_start got %b want 0", tx_start_en); end
        checks++; if (fifo_rd_water_level !== 12'd180) begin errors++; $display("FAIL rms_fifo_left got %0d want 180", fifo_rd_water_level); end
        rrst = 1'b0;
        rd0 = rd_cnt;
        wait_start(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL rms_relaunch_latency got %0d want 9", lat); end
        checks++; if (tx_byte_num !== 16'd180) begin errors++; $display("FAIL rms_relaunch_byte_num got %0d want 180", tx_byte_num); end
        drive_req(180);
        idle_cycles(2);
        checks++; if (rd_cnt - rd0 != 180) begin errors++; $display("FAIL rms_relaunch_reads got %0d want 180", rd_cnt - rd0); end
        pulse_done();
        checks++; if (order_err != 0) begin errors++; $display("FAIL rms_order got %0d errors want 0", order_err); end
    endtask

    initial begin
        test_reset();
        test_short_flush();
        test_full_burst();
        test_boundary();
        test_over_request();
        test_underrun();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
